// File: rtl/btn_rst_ctrl.sv
// Button synchroniser/debouncer plus SoC reset sequencer for zerosoc.
// Define BTN_RST_LONGPRESS_EN to allow a long press on btn_i[RstBtn] to issue a reset.
module btn_rst_lane #(
    parameter int DebounceCycles = 6000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic btn_o,
    output logic press_o,
    output logic release_o
);
    localparam int CntW = $clog2(DebounceCycles);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    logic [1:0]      sync_q;
    logic [CntW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            btn_o     <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_i};
            press_o   <= 1'b0;
            release_o <= 1'b0;
            if (sync_q[1] == btn_o) begin
                cnt_q <= '0;
            end else if (cnt_q == CntMax) begin
                // pulse in the same cycle the debounced level flips
                cnt_q     <= '0;
                btn_o     <= sync_q[1];
                press_o   <= sync_q[1];
                release_o <= ~sync_q[1];
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end
endmodule

module btn_rst_ctrl #(
    parameter int NumBtn          = 3,
    parameter int DebounceCycles  = 6000,
    parameter int LongPressCycles = 12_000_000,
    parameter int RstHoldCycles   = 16,
    parameter int RstBtn          = 0
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [NumBtn-1:0] btn_i,
    output logic [NumBtn-1:0] btn_o,
    output logic [NumBtn-1:0] press_o,
    output logic [NumBtn-1:0] release_o,
    output logic              soc_rst_no,
    output logic              rst_busy_o
);
    localparam int HoldW = (RstHoldCycles > 1) ? $clog2(RstHoldCycles) : 1;
    localparam logic [HoldW-1:0] HoldMax = HoldW'(RstHoldCycles - 1);

    if (DebounceCycles < 2 || RstHoldCycles < 1 || LongPressCycles < 1 ||
        RstBtn < 0 || RstBtn >= NumBtn) begin : g_bad_cfg
        $error("btn_rst_ctrl: illegal parameter combination");
    end

    for (genvar i = 0; i < NumBtn; i++) begin : g_lane
        btn_rst_lane #(.DebounceCycles(DebounceCycles)) u_lane (
            .clk_i    (clk_i),
            .rst_ni   (rst_ni),
            .btn_i    (btn_i[i]),
            .btn_o    (btn_o[i]),
            .press_o  (press_o[i]),
            .release_o(release_o[i])
        );
    end

`ifdef BTN_RST_LONGPRESS_EN
    typedef enum logic [1:0] {HOLD, IDLE, ARMED, WAIT_REL} state_e;

    localparam int LongW = (LongPressCycles > 1) ? $clog2(LongPressCycles) : 1;
    localparam logic [LongW-1:0] LongMax = LongW'(LongPressCycles - 1);

    logic             rst_lvl;
    logic [LongW-1:0] long_q, long_d;

    assign rst_lvl = btn_o[RstBtn];
`else
    typedef enum logic [1:0] {HOLD, IDLE} state_e;
`endif

    state_e           state_q, state_d;
    logic [HoldW-1:0] hold_q, hold_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= HOLD;
            hold_q     <= '0;
            soc_rst_no <= 1'b0;
            rst_busy_o <= 1'b1;
`ifdef BTN_RST_LONGPRESS_EN
            long_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            soc_rst_no <= (state_d != HOLD);
            rst_busy_o <= (state_d == HOLD);
`ifdef BTN_RST_LONGPRESS_EN
            long_q     <= long_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
`ifdef BTN_RST_LONGPRESS_EN
        long_d  = long_q;
`endif
        case (state_q)
            HOLD: begin
                if (hold_q == HoldMax) begin
                    hold_d = '0;
`ifdef BTN_RST_LONGPRESS_EN
                    // still held after the reset: wait for release before re-arming
                    state_d = rst_lvl ? WAIT_REL : IDLE;
`else
                    state_d = IDLE;
`endif
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            IDLE: begin
`ifdef BTN_RST_LONGPRESS_EN
                long_d = '0;
                if (rst_lvl) state_d = ARMED;
`endif
            end
`ifdef BTN_RST_LONGPRESS_EN
            ARMED: begin
                // release has priority over the terminal count
                if (!rst_lvl) begin
                    state_d = IDLE;
                end else if (long_q == LongMax) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end else begin
                    long_d = long_q + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!rst_lvl) state_d = IDLE;
            end
`endif
            default: state_d = HOLD;
        endcase
    end
endmodule

// File: tb/tb_btn_rst_ctrl.sv
// Scoreboard bench for btn_rst_ctrl: stimulus queues timed events, a negedge monitor matches them.
module tb_btn_rst_ctrl;
    localparam int NB = 3;
    localparam int K_BTN = 0, K_PRS = 1, K_REL = 2, K_RST = 3;

    typedef struct {
        int kind;
        int idx;
        int cyc;
        int val;
    } ev_t;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b1;
    logic [NB-1:0] btn_i = '0;
    logic [NB-1:0] btn_o, press_o, release_o;
    logic          soc_rst_no, rst_busy_o;

    int  cyc = 0;
    int  compared = 0;
    int  mismatched = 0;
    ev_t exp_q[$];

    logic [NB-1:0] prev_btn = '0;
    logic [1:0]    prev_rst = 2'b01;

    btn_rst_ctrl #(
        .NumBtn(NB), .DebounceCycles(4), .LongPressCycles(20),
        .RstHoldCycles(3), .RstBtn(0)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_i(btn_i), .btn_o(btn_o),
        .press_o(press_o), .release_o(release_o),
        .soc_rst_no(soc_rst_no), .rst_busy_o(rst_busy_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) cyc <= cyc + 1;

    function automatic string kname(int k);
        case (k)
            K_BTN:   return "btn_o";
            K_PRS:   return "press_o";
            K_REL:   return "release_o";
            default: return "rst{soc_rst_no,busy}";
        endcase
    endfunction

    task automatic expect_ev(int kind, int idx, int c, int val);
        ev_t e;
        e.kind = kind; e.idx = idx; e.cyc = c; e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic observe(int kind, int idx, int val);
        int hit;
        hit = -1;
        foreach (exp_q[j])
            if (hit < 0 && exp_q[j].kind == kind && exp_q[j].idx == idx) hit = j;
        compared++;
        if (hit < 0) begin
            mismatched++;
            $display("FAIL unexpected %s[%0d]: got %0d at cycle %0d, expected no event",
                     kname(kind), idx, val, cyc);
        end else begin
            if (exp_q[hit].cyc != cyc || exp_q[hit].val != val) begin
                mismatched++;
                $display("FAIL %s[%0d]: got %0d at cycle %0d, expected %0d at cycle %0d",
                         kname(kind), idx, val, cyc, exp_q[hit].val, exp_q[hit].cyc);
            end
            exp_q.delete(hit);
        end
    endtask

    // monitor: every output change or pulse is an event that must have been predicted
    always @(negedge clk_i) begin
        for (int i = 0; i < NB; i++) begin
            if (btn_o[i] != prev_btn[i]) observe(K_BTN, i, int'(btn_o[i]));
            if (press_o[i])              observe(K_PRS, i, 1);
            if (release_o[i])            observe(K_REL, i, 1);
        end
        if ({soc_rst_no, rst_busy_o} != prev_rst) observe(K_RST, 0, int'({soc_rst_no, rst_busy_o}));
        prev_btn = btn_o;
        prev_rst = {soc_rst_no, rst_busy_o};
    end

    task automatic at(int c);
        while (cyc < c) @(negedge clk_i);
        #1;
    endtask

    task automatic check_rst(string nm);
        logic [10:0] got;
        got = {btn_o, press_o, release_o, soc_rst_no, rst_busy_o};
        compared++;
        if (got !== 11'b000_000_000_0_1) begin
            mismatched++;
            $display("FAIL %s: got %b, expected %b", nm, got, 11'b000_000_000_0_1);
        end
    endtask

    task automatic press_ev(int idx, int c);
        expect_ev(K_BTN, idx, c, 1);
        expect_ev(K_PRS, idx, c, 1);
    endtask

    task automatic release_ev(int idx, int c);
        expect_ev(K_BTN, idx, c, 0);
        expect_ev(K_REL, idx, c, 1);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        btn_i = '1;
        #1 rst_ni = 1'b0;
        at(2);
        check_rst("reset_state");

        // power-on stretch: 3 HOLD cycles after release
        at(3);
        btn_i  = '0;
        rst_ni = 1'b1;
        expect_ev(K_RST, 0, 6, 2'b10);

        // clean press/release on button 1: 2 sync + 4 debounce cycles
        at(10); btn_i[1] = 1'b1; press_ev(1, 16);
        at(25); btn_i[1] = 1'b0; release_ev(1, 31);

        // 3-cycle glitch is rejected, 4-cycle pulse is accepted
        at(40); btn_i[2] = 1'b1;
        at(43); btn_i[2] = 1'b0;
        at(60); btn_i[2] = 1'b1; press_ev(2, 66);
        at(64); btn_i[2] = 1'b0; release_ev(2, 70);

`ifdef BTN_RST_LONGPRESS_EN
        // long press: ARMED at 87, terminal count at 107, HOLD 107..109, held -> WAIT_REL
        at(80);  btn_i[0] = 1'b1; press_ev(0, 86);
        expect_ev(K_RST, 0, 107, 2'b01);
        expect_ev(K_RST, 0, 110, 2'b10);
        at(210); btn_i[0] = 1'b0; release_ev(0, 216);
        at(225); btn_i[0] = 1'b1; press_ev(0, 231);
        expect_ev(K_RST, 0, 252, 2'b01);
        expect_ev(K_RST, 0, 255, 2'b10);
        at(270); btn_i[0] = 1'b0; release_ev(0, 276);

        // early release, then release exactly in the terminal ARMED cycle
        at(300); btn_i[0] = 1'b1; press_ev(0, 306);
        at(315); btn_i[0] = 1'b0; release_ev(0, 321);
        at(340); btn_i[0] = 1'b1; press_ev(0, 346);
        at(360); btn_i[0] = 1'b0; release_ev(0, 366);

        // reset asserted in the 2nd HOLD cycle of a long-press reset
        at(390); btn_i[0] = 1'b1; press_ev(0, 396);
        expect_ev(K_RST, 0, 417, 2'b01);
        at(418); rst_ni = 1'b0; btn_i[0] = 1'b0;
        expect_ev(K_BTN, 0, 419, 0);
        at(420); check_rst("reset_mid_longpress_hold");
        at(421); rst_ni = 1'b1;
        expect_ev(K_RST, 0, 424, 2'b10);
`else
        // without the long-press feature a held RstBtn never resets
        at(80);  btn_i[0] = 1'b1; press_ev(0, 86);
        at(150); btn_i[0] = 1'b0; release_ev(0, 156);
`endif

        // reset re-asserted in the 2nd power-on HOLD cycle restarts the full stretch
        at(450); btn_i = '1; rst_ni = 1'b0;
        expect_ev(K_RST, 0, 451, 2'b01);
        at(453); rst_ni = 1'b1;
        at(454); rst_ni = 1'b0;
        at(455); check_rst("reset_mid_poweron_hold");
        at(456); btn_i = '0; rst_ni = 1'b1;
        expect_ev(K_RST, 0, 459, 2'b10);

        at(480);
        foreach (exp_q[j]) begin
            compared++;
            mismatched++;
            $display("FAIL missing %s[%0d]: got no event, expected %0d at cycle %0d",
                     kname(exp_q[j].kind), exp_q[j].idx, exp_q[j].val, exp_q[j].cyc);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
